// File: rtl/store_buffer_if.sv
// Port bundle for the store buffer: MEM-stage store/load-check side plus the data-cache write side.
interface store_buffer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready;
  logic              st_misaligned;
  logic              ld_check_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_mbe;
  logic              dmem_resp;
  logic              sb_empty;

  modport master (
    output st_valid, st_funct3, st_addr, st_data, ld_check_valid, ld_addr, dmem_resp,
    input  st_ready, st_misaligned, ld_conflict, dmem_write, dmem_address, dmem_wdata,
           dmem_mbe, sb_empty
  );

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, ld_check_valid, ld_addr, dmem_resp,
    output st_ready, st_misaligned, ld_conflict, dmem_write, dmem_address, dmem_wdata,
           dmem_mbe, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: formats sb/sh/sw into word writes, queues them and drains to the dcache.
// Optional same-word merging into the tail entry under STB_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int DEPTH_W = $clog2(DEPTH);
  localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-3:0] wa;
    logic [31:0]       wdata;
    logic [3:0]        mbe;
  } ent_t;

  typedef enum logic {IDLE, WRITE} state_t;

  ent_t               ents [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [DEPTH_W-1:0] head, tail;
  logic [DEPTH_W:0]   count, count_nxt;
  state_t             state;

  logic [1:0]  o;
  logic        legal;
  logic [31:0] fwd;
  logic [3:0]  fmbe;

  always_comb begin
    o     = sb.st_addr[1:0];
    legal = 1'b0;
    fwd   = '0;
    fmbe  = '0;
    case (sb.st_funct3)
      3'b000: begin legal = 1'b1;         fwd = {4{sb.st_data[7:0]}};  fmbe = 4'b0001 << o; end
      3'b001: begin legal = !o[0];        fwd = {2{sb.st_data[15:0]}}; fmbe = 4'b0011 << {o[1], 1'b0}; end
      3'b010: begin legal = (o == 2'b00); fwd = sb.st_data;            fmbe = 4'b1111; end
      default: ;
    endcase
  end

  logic full, merge_ok, accept, alloc, merge, pop;
  ent_t head_ent;

  assign full = (count == CNT_FULL);

`ifdef STB_COALESCE_EN
  logic [DEPTH_W-1:0] last;
  logic [31:0]        mrg_wdata;
  logic [3:0]         mrg_mbe;

  assign last = tail - 1'b1;
  // The head is frozen once WRITE has latched it; in IDLE a merge into it is folded into the load below.
  assign merge_ok = (count != '0) && (ents[last].wa == sb.st_addr[ADDR_W-1:2]) &&
                    !(state == WRITE && last == head);
  assign mrg_mbe  = ents[last].mbe | fmbe;
  for (genvar b = 0; b < 4; b++) begin : g_mrg
    assign mrg_wdata[8*b +: 8] = fmbe[b] ? fwd[8*b +: 8] : ents[last].wdata[8*b +: 8];
  end
  assign head_ent = (merge && last == head) ?
                    '{wa: ents[head].wa, wdata: mrg_wdata, mbe: mrg_mbe} : ents[head];
`else
  assign merge_ok = 1'b0;
  assign head_ent = ents[head];
`endif

  assign sb.st_ready = !full || merge_ok;
  assign accept      = sb.st_valid && legal && sb.st_ready;
  assign merge       = accept && merge_ok;
  assign alloc       = accept && !merge_ok;
  assign pop         = (state == WRITE) && sb.dmem_resp;

  always_comb begin
    count_nxt = count;
    if (alloc && !pop)      count_nxt = count + 1'b1;
    else if (!alloc && pop) count_nxt = count - 1'b1;
  end

  // The accept-cycle store is not compared; it is one pipeline stage ahead of the load.
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld[i] && (ents[i].wa == sb.ld_addr[ADDR_W-1:2]);
  end
  assign sb.ld_conflict = sb.ld_check_valid && (|hit);

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^sb.ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld              <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      state            <= IDLE;
      sb.dmem_write    <= 1'b0;
      sb.dmem_address  <= '0;
      sb.dmem_wdata    <= '0;
      sb.dmem_mbe      <= '0;
      sb.st_misaligned <= 1'b0;
      sb.sb_empty      <= 1'b1;
    end else begin
      count            <= count_nxt;
      sb.sb_empty      <= (count_nxt == '0);
      sb.st_misaligned <= sb.st_valid && !legal;
      if (alloc) begin
        ents[tail] <= '{wa: sb.st_addr[ADDR_W-1:2], wdata: fwd, mbe: fmbe};
        vld[tail]  <= 1'b1;
        tail       <= tail + 1'b1;
      end
`ifdef STB_COALESCE_EN
      if (merge) begin
        ents[last].wdata <= mrg_wdata;
        ents[last].mbe   <= mrg_mbe;
      end
`endif
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case (state)
        IDLE: if (count != '0) begin
          state           <= WRITE;
          sb.dmem_write   <= 1'b1;
          sb.dmem_address <= {head_ent.wa, 2'b00};
          sb.dmem_wdata   <= head_ent.wdata;
          sb.dmem_mbe     <= head_ent.mbe;
        end
        WRITE: if (sb.dmem_resp) begin
          state         <= IDLE;
          sb.dmem_write <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: formatting vectors, corner sequences, randomized queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.ADDR_W(32)) bus ();
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .sb(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, d;
    logic        ok;
    logic [31:0] ea, ew;
    logic [3:0]  em;
  } vec_t;

  typedef struct {
    logic [31:0] a, w;
    logic [3:0]  m;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.st_valid = 0; bus.st_funct3 = 0; bus.st_addr = 0; bus.st_data = 0;
    bus.ld_check_valid = 0; bus.ld_addr = 0; bus.dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic put(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1; bus.st_funct3 = f; bus.st_addr = a; bus.st_data = d;
    tick();
    bus.st_valid = 0;
  endtask

  task automatic wait_wr(input string name);
    int n = 0;
    while (!bus.dmem_write && n < 20) begin tick(); n++; end
    chk({name, "_wait"}, 32'(bus.dmem_write), 32'd1);
  endtask

  task automatic resp();
    bus.dmem_resp = 1;
    tick();
    bus.dmem_resp = 0;
  endtask

  function automatic void fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                              output logic ok, output logic [31:0] w, output logic [3:0] m);
    int o = int'(a[1:0]);
    ok = 0; w = 0; m = 0;
    if (f == 3'd0) begin
      ok = 1; w = {24'h0, d[7:0]} * 32'h01010101; m = 4'(1 << o);
    end else if (f == 3'd1 && (o % 2) == 0) begin
      ok = 1; w = {16'h0, d[15:0]} * 32'h00010001; m = 4'(3 << o);
    end else if (f == 3'd2 && o == 0) begin
      ok = 1; w = d; m = 4'hF;
    end
  endfunction

  task automatic run_random();
    ent_t q[$];
    ent_t e;
    logic busy = 0;
    logic ok, exp_ready, mrg_ok, conf, misal_n, busy_n;
    logic [31:0] w;
    logic [3:0] m;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.st_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2: bus.st_funct3 = 3'd0;
        3, 4:    bus.st_funct3 = 3'd1;
        5, 6:    bus.st_funct3 = 3'd2;
        default: bus.st_funct3 = 3'($urandom_range(3, 7));
      endcase
      bus.st_addr = 32'h9000 + $urandom_range(0, 15);
      bus.st_data = $urandom;
      bus.ld_check_valid = 1'($urandom_range(0, 1));
      bus.ld_addr = 32'h9000 + $urandom_range(0, 19);
      bus.dmem_resp = ($urandom_range(0, 3) == 0);
      #1;
      fmt(bus.st_funct3, bus.st_addr, bus.st_data, ok, w, m);
      mrg_ok = COAL && q.size() > 0 && q[q.size()-1].a == {bus.st_addr[31:2], 2'b00} &&
               !(busy && q.size() == 1);
      exp_ready = (q.size() != DEPTH) || mrg_ok;
      conf = 0;
      foreach (q[i]) if (q[i].a[31:2] == bus.ld_addr[31:2]) conf = 1;
      conf = conf && bus.ld_check_valid;
      chk("rnd_ready", 32'(bus.st_ready), 32'(exp_ready));
      chk("rnd_conflict", 32'(bus.ld_conflict), 32'(conf));
      chk("rnd_write", 32'(bus.dmem_write), 32'(busy));
      if (busy) begin
        chk("rnd_addr", bus.dmem_address, q[0].a);
        chk("rnd_wdata", bus.dmem_wdata, q[0].w);
        chk("rnd_mbe", 32'(bus.dmem_mbe), 32'(q[0].m));
      end
      busy_n  = busy ? !bus.dmem_resp : (q.size() > 0);
      misal_n = bus.st_valid && !ok;
      if (bus.st_valid && ok && exp_ready) begin
        if (mrg_ok) begin
          e = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (m[b]) e.w[8*b +: 8] = w[8*b +: 8];
          e.m = e.m | m;
          q[q.size()-1] = e;
        end else begin
          e.a = {bus.st_addr[31:2], 2'b00}; e.w = w; e.m = m;
          q.push_back(e);
        end
      end
      if (busy && bus.dmem_resp) void'(q.pop_front());
      busy = busy_n;
      @(posedge clk);
      #1;
      chk("rnd_misal", 32'(bus.st_misaligned), 32'(misal_n));
      chk("rnd_empty", 32'(bus.sb_empty), 32'(q.size() == 0));
    end
    idle_in();
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{3'b000, 32'h1003, 32'h000000AB, 1'b1, 32'h1000, 32'hABABABAB, 4'b1000};
    vt[1] = '{3'b001, 32'h2002, 32'h1234CAFE, 1'b1, 32'h2000, 32'hCAFECAFE, 4'b1100};
    vt[2] = '{3'b001, 32'h2001, 32'h1234CAFE, 1'b0, 32'h0,    32'h0,        4'b0000};
    vt[3] = '{3'b010, 32'h3000, 32'hDEADBEEF, 1'b1, 32'h3000, 32'hDEADBEEF, 4'b1111};
    vt[4] = '{3'b010, 32'h3002, 32'hDEADBEEF, 1'b0, 32'h0,    32'h0,        4'b0000};
    vt[5] = '{3'b000, 32'h5001, 32'h00000077, 1'b1, 32'h5000, 32'h77777777, 4'b0010};
    vt[6] = '{3'b001, 32'h6000, 32'h0000ABCD, 1'b1, 32'h6000, 32'hABCDABCD, 4'b0011};
    vt[7] = '{3'b100, 32'h7000, 32'h11111111, 1'b0, 32'h0,    32'h0,        4'b0000};
    vt[8] = '{3'b000, 32'h7002, 32'h12345699, 1'b1, 32'h7000, 32'h99999999, 4'b0100};

    do_reset();
    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_misal", 32'(bus.st_misaligned), 32'd0);
    chk("rst_write", 32'(bus.dmem_write), 32'd0);
    chk("rst_addr", bus.dmem_address, 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_mbe", 32'(bus.dmem_mbe), 32'd0);
    chk("rst_empty", 32'(bus.sb_empty), 32'd1);
    bus.ld_check_valid = 1; #1;
    chk("rst_conflict", 32'(bus.ld_conflict), 32'd0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      put(vt[i].f, vt[i].a, vt[i].d);
      chk($sformatf("v%0d_misal", i), 32'(bus.st_misaligned), 32'(!vt[i].ok));
      chk($sformatf("v%0d_wr_early", i), 32'(bus.dmem_write), 32'd0);
      if (vt[i].ok) begin
        tick();
        chk($sformatf("v%0d_wr_rise", i), 32'(bus.dmem_write), 32'd1);
        chk($sformatf("v%0d_addr", i), bus.dmem_address, vt[i].ea);
        chk($sformatf("v%0d_wdata", i), bus.dmem_wdata, vt[i].ew);
        chk($sformatf("v%0d_mbe", i), 32'(bus.dmem_mbe), 32'(vt[i].em));
        resp();
        chk($sformatf("v%0d_empty", i), 32'(bus.sb_empty), 32'd1);
        chk($sformatf("v%0d_wr_low", i), 32'(bus.dmem_write), 32'd0);
      end else begin
        chk($sformatf("v%0d_empty", i), 32'(bus.sb_empty), 32'd1);
        chk($sformatf("v%0d_ready", i), 32'(bus.st_ready), 32'd1);
        tick();
        chk($sformatf("v%0d_misal_end", i), 32'(bus.st_misaligned), 32'd0);
        chk($sformatf("v%0d_nowr", i), 32'(bus.dmem_write), 32'd0);
      end
    end

    // Fill to DEPTH, hold a fifth store, release one slot, then check drain order.
    do_reset();
    for (int k = 0; k < 4; k++) put(3'b010, 32'h100 + 32'(4*k), 32'hA0 + 32'(k));
    chk("full_ready", 32'(bus.st_ready), 32'd0);
    bus.st_valid = 1; bus.st_funct3 = 3'b010; bus.st_addr = 32'h110; bus.st_data = 32'hA4;
    tick();
    chk("held_ready", 32'(bus.st_ready), 32'd0);
    chk("held_write", 32'(bus.dmem_write), 32'd1);
    chk("order_0", bus.dmem_address, 32'h100);
    bus.dmem_resp = 1; #1;
    chk("pop_cycle_ready", 32'(bus.st_ready), 32'd0);
    tick();
    bus.dmem_resp = 0;
    chk("after_pop_ready", 32'(bus.st_ready), 32'd1);
    tick();
    bus.st_valid = 0;
    chk("refill_ready", 32'(bus.st_ready), 32'd0);
    for (int k = 1; k < 5; k++) begin
      wait_wr($sformatf("order_%0d", k));
      chk($sformatf("order_%0d_addr", k), bus.dmem_address, 32'h100 + 32'(4*k));
      chk($sformatf("order_%0d_wdata", k), bus.dmem_wdata, 32'hA0 + 32'(k));
      resp();
    end
    chk("order_empty", 32'(bus.sb_empty), 32'd1);

    // Load-address hazard against a pending word.
    do_reset();
    put(3'b010, 32'h3000, 32'h1);
    bus.ld_check_valid = 1; bus.ld_addr = 32'h3002; #1;
    chk("ldc_hit", 32'(bus.ld_conflict), 32'd1);
    bus.ld_addr = 32'h3004; #1;
    chk("ldc_miss", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_valid = 0; bus.ld_addr = 32'h3002; #1;
    chk("ldc_novalid", 32'(bus.ld_conflict), 32'd0);
    wait_wr("ldc");
    resp();
    bus.ld_check_valid = 1; #1;
    chk("ldc_drained", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_valid = 0;

    // Reset with three entries and the head in flight.
    do_reset();
    for (int k = 0; k < 3; k++) put(3'b010, 32'h500 + 32'(4*k), 32'h5);
    chk("rmw_inflight", 32'(bus.dmem_write), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("rmw_write", 32'(bus.dmem_write), 32'd0);
    chk("rmw_empty", 32'(bus.sb_empty), 32'd1);
    chk("rmw_ready", 32'(bus.st_ready), 32'd1);
    bus.ld_check_valid = 1; bus.ld_addr = 32'h504; #1;
    chk("rmw_conflict", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_valid = 0;
    tick();
    chk("rmw_stay_idle", 32'(bus.dmem_write), 32'd0);

    // Two byte stores to one word behind a busy head.
    do_reset();
    put(3'b010, 32'h8000, 32'h55);
    put(3'b000, 32'h4000, 32'h11);
    put(3'b000, 32'h4001, 32'h22);
    wait_wr("co_head");
    chk("co_head_addr", bus.dmem_address, 32'h8000);
    resp();
    wait_wr("co_first");
    chk("co_first_addr", bus.dmem_address, 32'h4000);
`ifdef STB_COALESCE_EN
    chk("co_mbe", 32'(bus.dmem_mbe), 32'b0011);
    chk("co_wdata_lo", 32'(bus.dmem_wdata[15:0]), 32'h2211);
    resp();
    tick(); tick();
    chk("co_single", 32'(bus.dmem_write), 32'd0);
    chk("co_empty", 32'(bus.sb_empty), 32'd1);
`else
    chk("co_mbe0", 32'(bus.dmem_mbe), 32'b0001);
    chk("co_wdata0", bus.dmem_wdata, 32'h11111111);
    resp();
    wait_wr("co_second");
    chk("co_addr1", bus.dmem_address, 32'h4000);
    chk("co_mbe1", 32'(bus.dmem_mbe), 32'b0010);
    chk("co_wdata1", bus.dmem_wdata, 32'h22222222);
    resp();
    chk("co_empty", 32'(bus.sb_empty), 32'd1);
`endif

    run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store-side counterpart of the load path (lw/lb/lbu/lh/lhu regfilemux selects).
- Accepts sb/sh/sw from the MEM stage and formats each into a word-aligned write with a byte mask.
- Queues stores in a small FIFO and drains them to the data cache over the read/write/resp handshake.
- Flags loads whose word address matches a pending store, so the hazard unit stalls them.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_valid  in  1  MEM-stage store request
- st_funct3  in  3  000=sb, 001=sh, 010=sw
- st_addr  in  ADDR_W  byte address
- st_data  in  32  rs2 value after forwarding
- st_ready  out  1  buffer can accept a store this cycle
- st_misaligned  out  1  one-cycle pulse: request rejected
- ld_check_valid  in  1  MEM-stage load present
- ld_addr  in  ADDR_W  load byte address
- ld_conflict  out  1  load must stall
- dmem_write  out  1  cache write request
- dmem_address  out  ADDR_W  word-aligned address, [1:0]=00
- dmem_wdata  out  32  replicated store data
- dmem_mbe  out  4  byte enables
- dmem_resp  in  1  cache write complete
- sb_empty  out  1  no valid entries (fence/drain)

Behaviour:
- Reset: st_ready=1, st_misaligned=0, ld_conflict=0, dmem_write=0, dmem_address/wdata/mbe=0, sb_empty=1, count=0, pointers=0, FSM=IDLE.
- Reset mid-write drops every entry, including the in-flight head. dmem_write is low the cycle after rst.
- st_ready = (count != DEPTH). It comes from registered count only; there is no same-cycle bypass of a dequeue.
- Accept occurs when st_valid && st_ready && legal. The entry is written at the clock edge, so it is visible to ld_conflict and drain the next cycle.
- Formatting, with o = addr[1:0]:
  - sb: wdata = {4{data[7:0]}}, mbe = 4'b0001 << o.
  - sh: wdata = {2{data[15:0]}}, mbe = 4'b0011 << {o[1],1'b0}.
  - sw: wdata = data, mbe = 4'b1111.
  - Stored address = {addr[ADDR_W-1:2], 2'b00}.
- Illegal requests: sh with o[0]=1, sw with o!=0, or any other funct3.
  - Not enqueued.
  - st_misaligned pulses high the following cycle.
  - count unchanged.
  - st_ready is unaffected.
- Drain FSM:
  - IDLE: if count>0, go to WRITE next cycle.
  - WRITE: dmem_write=1 with head fields held stable. On dmem_resp, pop the head and go to IDLE.
  - Consequence: dmem_write is low for exactly one cycle between back-to-back stores. Throughput is one store per (cache latency + 1) cycles.
- Simultaneous enqueue and dmem_resp pop: count unchanged, both pointers advance.
- Full with pop in the same cycle: st_ready stays 0 that cycle and becomes 1 the next.
- Pointers wrap modulo DEPTH. Count is DEPTH_W+1 bits wide so full and empty are distinguishable.
- ld_conflict (combinational) = ld_check_valid && (ld_addr[ADDR_W-1:2] matches any valid entry, including the in-flight head).
  - A store being accepted the same cycle is not compared; the pipeline orders it one stage earlier.
- sb_empty = (count == 0), registered.
- dmem_resp while in IDLE is ignored.

Optional Feature:
- Macro: STB_COALESCE_EN.
- When defined, an accepted store whose word address equals the tail entry (most recent valid entry) merges into that entry instead of allocating a new one:
  - mbe_new = mbe_tail | mbe_in.
  - Bytes enabled in mbe_in overwrite those bytes of wdata.
- Merging is never allowed into the head while in WRITE; in that case a new entry is allocated.
- Merging is allowed while the buffer is full. st_ready stays 0 only when no merge is possible.
- When not defined, every accepted store allocates its own entry.

Test Plan:
- Reset, then sb addr=0x1003 data=0xAB.
  - Response: dmem_address=0x1000, wdata=0xABABABAB, mbe=4'b1000, dmem_write rises 2 cycles after st_valid.
  - After dmem_resp: sb_empty=1.
- sh addr=0x2002 data=0x1234CAFE → wdata=0xCAFECAFE, mbe=4'b1100. sh addr=0x2001 → st_misaligned=1 for one cycle, count unchanged.
- Five sw with dmem_resp held low.
  - st_ready=0 after the 4th accept; the 5th is held.
  - One dmem_resp → st_ready=1 next cycle and the 5th is accepted.
  - Drain order matches issue order.
- Pending sw to 0x3000, load at 0x3002 → ld_conflict=1. Load at 0x3004 → 0. After drain, load at 0x3002 → 0.
- rst asserted mid-WRITE with 3 entries → next cycle dmem_write=0, sb_empty=1, st_ready=1.
- With STB_COALESCE_EN: sb 0x4000=0x11 then sb 0x4001=0x22 while the head is busy.
  - A single entry is written: mbe=4'b0011, wdata[15:0]=0x2211.
  - Without the macro, two entries are written.
